// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants for the multiplexed 7-segment scanner:
//                default digit count and the {g,f,e,d,c,b,a} glyph set.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

  // Default number of multiplexed digits on the board display.
  localparam int SEG_NUM_DIGITS = 8;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}. b and d are lowercase.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg
//  Description : Combinational hex nibble to 7-segment glyph decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Map each nibble value onto its glyph constant.
  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan
//  Description : Time-multiplexed 7-segment scanner. A slow square wave from
//                the clock divider is synchronised into clk; each rising edge
//                advances one digit. A frame snapshot of hex_in/dp_in is taken
//                on every wrap to digit 0 so a scan never mixes two words.
//                Optional leading-zero blanking: define SEG_SCAN_LZ_BLANK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = SEG_NUM_DIGITS,  // 2..8
  parameter int IDX_W      = 3                // must equal clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_clk,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Synchroniser and edge-detector state.
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s_prev_q, s_prev_d;
  logic tick;

  // Scan state and captured frame.
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic [4*NUM_DIGITS-1:0] frame_hex_q, frame_hex_d;
  logic [NUM_DIGITS-1:0]   frame_dp_q, frame_dp_d;

  // Next-digit selection.
  logic [IDX_W-1:0]        idx_nxt;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] src_hex;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              glyph;
  logic [6:0]              glyph_shown;

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0]   blank_mask_q, blank_mask_d;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   src_blank;
  logic                    sel_blank;
`endif

  // scan_clk is plain data here: two-flop synchroniser plus a history flop.
  always_comb begin
    s1_d     = scan_clk;
    s2_d     = s1_q;
    s_prev_d = s2_q;
  end

  assign tick = s2_q & ~s_prev_q;

  // Work out the index the next tick moves to; on a wrap the live inputs
  // are the new frame, so they feed the decoder on that same edge.
  always_comb begin
    idx_nxt = (digit_idx_q == C_LAST_IDX) ? '0 : digit_idx_q + IDX_W'(1);
    wrap    = (idx_nxt == '0);
    src_hex = wrap ? hex_in : frame_hex_q;
    src_dp  = wrap ? dp_in  : frame_dp_q;
  end

  // Pick the nibble, dp bit and one-hot anode for the next index.
  always_comb begin
    sel_nib = 4'h0;
    sel_dp  = 1'b0;
    an_sel  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IDX_W'(k)) begin
        sel_nib   = src_hex[4*k +: 4];
        sel_dp    = src_dp[k];
        an_sel[k] = 1'b1;
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .hex (sel_nib),
    .seg (glyph)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Digit k is a leading zero when it and every digit to its left are zero;
  // digit 0 always shows so an all-zero word still reads "0".
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero   = all_zero & (hex_in[4*k +: 4] == 4'h0);
      lz_mask[k] = all_zero & (k != 0);
    end
  end

  // Blank the glyph (not the dp, not the anode) of a leading-zero digit.
  always_comb begin
    src_blank = wrap ? lz_mask : blank_mask_q;
    sel_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IDX_W'(k)) begin
        sel_blank = src_blank[k];
      end
    end
    glyph_shown = sel_blank ? SEG_BLANK : glyph;
  end
`else
  assign glyph_shown = glyph;
`endif

  // Advance the scan on tick; everything holds between ticks.
  always_comb begin
    digit_idx_d = digit_idx_q;
    an_d        = an_q;
    seg_d       = seg_q;
    frame_hex_d = frame_hex_q;
    frame_dp_d  = frame_dp_q;
`ifdef SEG_SCAN_LZ_BLANK_EN
    blank_mask_d = blank_mask_q;
`endif
    if (tick) begin
      digit_idx_d = idx_nxt;
      an_d        = en ? an_sel : '0;
      seg_d       = {sel_dp, glyph_shown};
      if (wrap) begin
        frame_hex_d = hex_in;
        frame_dp_d  = dp_in;
`ifdef SEG_SCAN_LZ_BLANK_EN
        blank_mask_d = lz_mask;
`endif
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s_prev_q    <= 1'b0;
      digit_idx_q <= C_LAST_IDX;
      an_q        <= '0;
      seg_q       <= '0;
      frame_hex_q <= '0;
      frame_dp_q  <= '0;
`ifdef SEG_SCAN_LZ_BLANK_EN
      blank_mask_q <= '0;
`endif
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s_prev_q    <= s_prev_d;
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      frame_hex_q <= frame_hex_d;
      frame_dp_q  <= frame_dp_d;
`ifdef SEG_SCAN_LZ_BLANK_EN
      blank_mask_q <= blank_mask_d;
`endif
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign digit_idx = digit_idx_q;

endmodule : seg_scan
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan
//  Description : Self-checking bench for seg_scan. Stimulus pushes the
//                hand-computed response of every scan_clk edge, tagged with
//                the clk cycle it must appear on; a monitor pops and compares,
//                and flags any output change that no edge accounts for.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_clk;
  logic        en;
  logic [31:0] hex_in;
  logic [7:0]  dp_in;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [2:0]  digit_idx;

`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    logic [2:0] idx;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Hand-computed glyphs: hex 0x01234567 (digit 0 first) and 0x89ABCDEF.
  logic [6:0] t1 [8] = '{7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [6:0] t3 [8] = '{7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};

  always #5 clk = ~clk;

  seg_scan #(
    .NUM_DIGITS (8),
    .IDX_W      (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_clk  (scan_clk),
    .en        (en),
    .hex_in    (hex_in),
    .dp_in     (dp_in),
    .an        (an),
    .seg       (seg),
    .digit_idx (digit_idx)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compare a due expectation, otherwise require outputs to hold.
  initial begin : monitor
    logic [18:0] prev;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = {an, seg, digit_idx};
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("an",  {24'h0, an},  {24'h0, e.an});
        check("seg", {24'h0, seg}, {24'h0, e.seg});
        check("idx", {29'h0, digit_idx}, {29'h0, e.idx});
        prev = {an, seg, digit_idx};
      end else begin
        check("hold", {13'h0, an, seg, digit_idx}, {13'h0, prev});
        prev = {an, seg, digit_idx};
      end
    end
  end

  // One full scan_clk period; the response must land on the 3rd clk edge.
  task automatic edge_exp(input logic [7:0] a, input logic [7:0] s, input logic [2:0] i);
    @(posedge clk);
    #1;
    scan_clk = 1'b1;
    sb.push_back('{an: a, seg: s, idx: i, due: cyc + 3});
    repeat (5) @(posedge clk);
    #1;
    scan_clk = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    scan_clk = 1'b0;
    en       = 1'b1;
    hex_in   = 32'h0123_4567;
    dp_in    = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_an",  {24'h0, an},  32'h0);
    check("rst_seg", {24'h0, seg}, 32'h0);
    check("rst_idx", {29'h0, digit_idx}, 32'h7);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic walk over 0x01234567.
    for (int k = 0; k < 8; k++) edge_exp(8'(1 << k), {1'b0, t1[k]}, 3'(k));

    // Mid-scan change has no effect until the wrap.
    hex_in = 32'h1111_1111;
    dp_in  = 8'h05;
    for (int k = 0; k < 4; k++)
      edge_exp(8'(1 << k), (k == 0 || k == 2) ? 8'h86 : 8'h06, 3'(k));
    hex_in = 32'h2222_2222;
    dp_in  = 8'hF0;
    for (int k = 4; k < 8; k++) edge_exp(8'(1 << k), 8'h06, 3'(k));
    for (int k = 0; k < 8; k++) edge_exp(8'(1 << k), (k >= 4) ? 8'hDB : 8'h5B, 3'(k));

    // en=0 for a full scan: no anodes, index and seg still advance.
    en     = 1'b0;
    hex_in = 32'h89AB_CDEF;
    dp_in  = 8'h00;
    for (int k = 0; k < 8; k++) edge_exp(8'h00, {1'b0, t3[k]}, 3'(k));
    en = 1'b1;
    edge_exp(8'h01, 8'h71, 3'd0);

    // Leading-zero frame 0x000000A0 queued behind the rest of this frame.
    hex_in = 32'h0000_00A0;
    for (int k = 1; k < 8; k++) edge_exp(8'(1 << k), {1'b0, t3[k]}, 3'(k));
    edge_exp(8'h01, 8'h3F, 3'd0);
    edge_exp(8'h02, 8'h77, 3'd1);
    for (int k = 2; k < 8; k++) edge_exp(8'(1 << k), LZ ? 8'h00 : 8'h3F, 3'(k));

    // All-zero word with dp on the leftmost digit.
    hex_in = 32'h0000_0000;
    dp_in  = 8'h80;
    edge_exp(8'h01, 8'h3F, 3'd0);
    for (int k = 1; k < 7; k++) edge_exp(8'(1 << k), LZ ? 8'h00 : 8'h3F, 3'(k));
    edge_exp(8'h80, LZ ? 8'h80 : 8'hBF, 3'd7);

    // Asynchronous reset while digit 5 is lit.
    hex_in = 32'h0123_4567;
    dp_in  = 8'h00;
    for (int k = 0; k < 6; k++) edge_exp(8'(1 << k), {1'b0, t1[k]}, 3'(k));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_an",  {24'h0, an},  32'h0);
    check("arst_seg", {24'h0, seg}, 32'h0);
    check("arst_idx", {29'h0, digit_idx}, 32'h7);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    edge_exp(8'h01, 8'h07, 3'd0);

    // scan_clk held high: a single advance, then frozen outputs.
    @(posedge clk);
    #1;
    scan_clk = 1'b1;
    sb.push_back('{an: 8'h02, seg: 8'h7D, idx: 3'd1, due: cyc + 3});
    repeat (2000) @(posedge clk);
    #1;
    scan_clk = 1'b0;
    repeat (5) @(posedge clk);

    // One-clk pulse: at most one advance.
    @(posedge clk);
    #1;
    scan_clk = 1'b1;
    sb.push_back('{an: 8'h04, seg: 8'h6D, idx: 3'd2, due: cyc + 3});
    @(posedge clk);
    #1;
    scan_clk = 1'b0;
    repeat (8) @(posedge clk);
    edge_exp(8'h08, 8'h66, 3'd3);

    // Bounded drain of outstanding expectations.
    for (int w = 0; w < 50 && sb.size() > 0; w++) @(posedge clk);
    check("drain", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_seg_scan
`default_nettype wire
